// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg -- shared definitions for the CP0 coprocessor slice.
//   CP0 register numbers, ExcCode values, exception handler address,
//   PRId constant and packed layouts of the SR / Cause state.
package cp0_unit_pkg;

    // CP0 register numbers (rd field of mtc0/mfc0)
    localparam logic [4:0] REG_COUNT = 5'd9;
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Handler entry address used by PC select when Req fires
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL     = 32'h2023_0711;

    // Writable SR fields; mapped to IM[15:10], EXL[1], IE[0]
    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    // Cause fields; mapped to BD[31], IP[15:10], ExcCode[6:2]
    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    function automatic logic [31:0] sr_word(input sr_t s);
        return {16'h0, s.im, 8'h0, s.exl, s.ie};
    endfunction

    function automatic logic [31:0] cause_word(input cause_t c);
        return {c.bd, 15'h0, c.ip, 3'h0, c.exc_code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_count.sv
// cp0_count -- free-running 32-bit Count register (CP0 reg 9).
//   Only instantiated when CP0_COUNT_EN is defined.
// Ports:
//   clk    in   clock
//   reset  in   async active-low reset, clears count
//   load   in   mtc0 to Count this cycle (takes priority over increment)
//   din    in   load value
//   count  out  current Count value
module cp0_count (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] din,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= 32'h0;
        else if (load)
            count <= din;
        else
            count <= count + 32'd1;   // wraps naturally at 0xFFFF_FFFF
    end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit -- MIPS-style coprocessor 0: SR, Cause, EPC, PRId and optional
//   Count (build with CP0_COUNT_EN to include register 9).
// Ports:
//   clk        in   clock
//   reset      in   async active-low reset
//   en         in   mtc0 write enable (M stage)
//   CP0Add     in   register number for mtc0/mfc0
//   CP0In      in   mtc0 write data
//   VPC        in   PC of M-stage instruction
//   BDIn       in   M-stage instruction is in a delay slot
//   ExcCodeIn  in   collected exception code, 0 = none
//   HWInt      in   level-sensitive interrupt lines
//   EXLClr     in   eret committing in M stage
//   CP0Out     out  mfc0 read data (pre-write value)
//   EPCOut     out  EPC register, for eret PC select
//   Req        out  exception/interrupt entry request (combinational)
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);

    sr_t         sr;
    cause_t      cause;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        mtc0_wr;
    logic [31:0] victim_pc;

    // Masked interrupts beat exceptions; EXL blocks any nested entry.
    assign int_req = (|(HWInt & sr.im)) & sr.ie & ~sr.exl;
    assign exc_req = (ExcCodeIn != EXC_INT) & ~sr.exl;
    // Gated by reset so Req drops the instant reset asserts, even with
    // an exception code still presented by the pipeline.
    assign Req     = reset & (int_req | exc_req);

    // An entry request squashes the mtc0 in the same instruction.
    assign mtc0_wr = en & ~Req;

    // Delay-slot victims restart at the branch, one word back.
    assign victim_pc = (VPC & ~32'h3) - (BDIn ? 32'd4 : 32'd0);

`ifdef CP0_COUNT_EN
    logic [31:0] count;

    cp0_count u_count (
        .clk   (clk),
        .reset (reset),
        .load  (mtc0_wr && (CP0Add == REG_COUNT)),
        .din   (CP0In),
        .count (count)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr    <= '0;
            cause <= '0;
            epc   <= 32'h0;
        end else begin
            cause.ip <= HWInt;
            if (Req) begin
                sr.exl         <= 1'b1;
                cause.bd       <= BDIn;
                cause.exc_code <= int_req ? EXC_INT : ExcCodeIn;
                epc            <= victim_pc;
            end else begin
                if (mtc0_wr && (CP0Add == REG_SR)) begin
                    sr.im  <= CP0In[15:10];
                    sr.ie  <= CP0In[0];
                    // eret in the same cycle overrides the written EXL bit
                    sr.exl <= CP0In[1] & ~EXLClr;
                end else if (EXLClr) begin
                    sr.exl <= 1'b0;
                end
                if (mtc0_wr && (CP0Add == REG_EPC))
                    epc <= CP0In;
            end
        end
    end

    always_comb begin
        CP0Out = 32'h0;
        case (CP0Add)
            REG_SR:    CP0Out = sr_word(sr);
            REG_CAUSE: CP0Out = cause_word(cause);
            REG_EPC:   CP0Out = epc;
            REG_PRID:  CP0Out = PRID_VAL;
`ifdef CP0_COUNT_EN
            REG_COUNT: CP0Out = count;
`endif
            default:   CP0Out = 32'h0;
        endcase
    end

    // No bypass: hazard logic keeps eret behind an mtc0 to EPC.
    assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit -- directed + randomized bench for cp0_unit with a
//   word-level reference model of the CP0 register file.
module tb_cp0_unit;

    logic        clk;
    logic        rst_n;
    logic        t_en;
    logic [4:0]  t_addr;
    logic [31:0] t_din;
    logic [31:0] t_vpc;
    logic        t_bd;
    logic [4:0]  t_exc;
    logic [5:0]  t_hw;
    logic        t_clr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state, kept as architectural 32-bit words
    logic [31:0] m_sr, m_cause, m_epc;
`ifdef CP0_COUNT_EN
    logic [31:0] m_cnt;
`endif

    cp0_unit dut (
        .clk       (clk),
        .reset     (rst_n),
        .en        (t_en),
        .CP0Add    (t_addr),
        .CP0In     (t_din),
        .VPC       (t_vpc),
        .BDIn      (t_bd),
        .ExcCodeIn (t_exc),
        .HWInt     (t_hw),
        .EXLClr    (t_clr),
        .CP0Out    (CP0Out),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_int();
        return ((t_hw & m_sr[15:10]) != 6'h0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int() || ((t_exc != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2023_0711;
`ifdef CP0_COUNT_EN
            5'd9:    return m_cnt;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_sr = 0; m_cause = 0; m_epc = 0;
`ifdef CP0_COUNT_EN
        m_cnt = 0;
`endif
    endtask

    task automatic model_edge(input logic r, input logic irq);
        m_cause[15:10] = t_hw;
        if (r) begin
            m_sr[1]       = 1'b1;
            m_cause[31]   = t_bd;
            m_cause[6:2]  = irq ? 5'd0 : t_exc;
            m_epc         = {t_vpc[31:2], 2'b00} - (t_bd ? 32'd4 : 32'd0);
        end else begin
            if (t_en && t_addr == 5'd12) begin
                m_sr = t_din & 32'h0000_FC03;
                if (t_clr) m_sr[1] = 1'b0;
            end else if (t_clr) begin
                m_sr[1] = 1'b0;
            end
            if (t_en && t_addr == 5'd14) m_epc = t_din;
        end
`ifdef CP0_COUNT_EN
        if (t_en && !r && t_addr == 5'd9) m_cnt = t_din;
        else m_cnt = m_cnt + 1;
`endif
    endtask

    task automatic drive(input logic en, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                         input logic [5:0] hw, input logic clr);
        t_en = en; t_addr = a; t_din = d; t_vpc = vpc;
        t_bd = bd; t_exc = exc; t_hw = hw; t_clr = clr;
    endtask

    // check combinational outputs against the model, then clock once
    task automatic step();
        logic r, irq;
        @(negedge clk);
        r   = model_req();
        irq = model_int();
        chk("req", {31'b0, Req}, {31'b0, r});
        chk("epc_out", EPCOut, m_epc);
        chk($sformatf("mfc0_%0d", t_addr), CP0Out, model_rd(t_addr));
        @(posedge clk);
        #1;
        model_edge(r, irq);
    endtask

    task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string tag);
        t_addr = a;
        #1;
        chk(tag, CP0Out, exp);
    endtask

    logic [4:0] addr_tab [8];
    logic [4:0] exc_tab  [8];

    initial begin
        addr_tab = '{5'd9, 5'd12, 5'd12, 5'd13, 5'd14, 5'd14, 5'd15, 5'd3};
        exc_tab  = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
        model_reset();
        drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        chk("rst_req", {31'b0, Req}, 32'h0);
        chk("rst_sr", CP0Out, 32'h0);
        chk("rst_epc", EPCOut, 32'h0);
        t_addr = 5'd15;
        #1;
        chk("rst_prid", CP0Out, 32'h2023_0711);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // enabled interrupt enters the handler, EPC = VPC
        drive(1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0); step();
        drive(0, 5'd14, 0, 32'h0000_3000, 0, 0, 6'b000001, 0);
        #1; chk("int_req_now", {31'b0, Req}, 32'h1);
        step();
        drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
        peek(5'd12, 32'h0000_0403, "int_sr");
        peek(5'd13, 32'h0000_0400, "int_cause");
        chk("int_epc", EPCOut, 32'h0000_3000);
        step();

        // eret, then a delay-slot RI exception
        drive(0, 5'd12, 0, 0, 0, 0, 0, 1); step();
        drive(0, 5'd13, 0, 32'h0000_3008, 1, 5'd10, 0, 0); step();
        drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
        peek(5'd13, 32'h8000_0028, "ri_cause");
        chk("ri_epc", EPCOut, 32'h0000_3004);

        // nested entry blocked while EXL
        drive(0, 5'd12, 0, 32'h0000_5000, 0, 5'd8, 6'h3f, 0);
        #1; chk("nest_req", {31'b0, Req}, 32'h0);
        step();
        chk("nest_epc", EPCOut, 32'h0000_3004);
        drive(0, 5'd12, 0, 0, 0, 0, 0, 1); step();
        drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
        peek(5'd12, 32'h0000_0401, "eret_sr");

        // mtc0 EPC squashed by same-cycle overflow
        drive(1, 5'd14, 32'h0000_3100, 32'h0000_4000, 0, 5'd12, 0, 0); step();
        chk("squash_epc", EPCOut, 32'h0000_4000);

        // mtc0 SR alongside eret: EXL cleared, IM/IE written
        drive(1, 5'd12, 32'h0000_FC03, 0, 0, 0, 0, 1); step();
        drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
        peek(5'd12, 32'h0000_FC01, "sr_eret_wr");
        drive(1, 5'd12, 32'h0, 0, 0, 0, 0, 0); step();

        // Count load and wrap
        drive(1, 5'd9, 32'hFFFF_FFFE, 0, 0, 0, 0, 0); step();
        drive(0, 5'd9, 0, 0, 0, 0, 0, 0); step(); step();
        peek(5'd9, 32'h0, "count_wrap");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 3) == 0, addr_tab[$urandom % 8], $urandom, $urandom,
                  1'($urandom), exc_tab[$urandom % 8],
                  (($urandom % 4) == 0) ? 6'($urandom) : 6'h0, ($urandom % 4) == 0);
            if (($urandom % 8) == 0) t_addr = 5'($urandom);
            step();
        end

        // reset mid-handler, no clock edge needed
        drive(0, 5'd13, 0, 32'h0000_6000, 0, 5'd4, 0, 0); step();
        drive(0, 5'd12, 0, 0, 0, 5'd5, 6'h3f, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_req", {31'b0, Req}, 32'h0);
        chk("mid_rst_sr", CP0Out, 32'h0);
        chk("mid_rst_epc", EPCOut, 32'h0);
        t_addr = 5'd13;
        #1;
        chk("mid_rst_cause", CP0Out, 32'h0);
        rst_n = 1'b1;
        t_exc = 5'd0;
        step();
        drive(0, 5'd12, 0, 0, 0, 0, 6'h3f, 0);
        #1; chk("post_rst_noint", {31'b0, Req}, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  mtc0 write enable from M stage.
REQ-004 CP0Add  input  5  register number for mtc0/mfc0 (rd field).
REQ-005 CP0In  input  32  mtc0 write data.
REQ-006 VPC  input  32  PC of the M-stage instruction (victim PC).
REQ-007 BDIn  input  1  M-stage instruction sits in a branch/jump delay slot.
REQ-008 ExcCodeIn  input  5  pipeline-collected exception code; 0 = none.
REQ-009 HWInt  input  6  external interrupt lines, level-sensitive.
REQ-010 EXLClr  input  1  eret committing in M stage.
REQ-011 CP0Out  output  32  mfc0 read data for CP0Add.
REQ-012 EPCOut  output  32  current EPC, consumed by PC select for eret.
REQ-013 Req  output  1  exception/interrupt entry request; flushes pipeline, PC <= handler 0x0000_4180.

Function
REQ-014 Registers: SR(12): IM[15:10], EXL[1], IE[0]; Cause(13): BD[31], IP[15:10], ExcCode[6:2]; EPC(14); PRId(15) constant 0x2023_0711; all other bits read 0.
REQ-015 IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL; ExcReq = (ExcCodeIn != 0) & !SR.EXL; Req = IntReq | ExcReq, combinational, same cycle.
REQ-016 Interrupt wins over simultaneous exception; recorded ExcCode = 0 for interrupt, else ExcCodeIn.
REQ-017 On Req at clock edge: SR.EXL <= 1; Cause.BD <= BDIn; Cause.ExcCode updated; EPC <= BDIn ? {VPC[31:2],2'b00} - 4 : {VPC[31:2],2'b00}.
REQ-018 Cause.IP <= HWInt every cycle, independent of masks and EXL.
REQ-019 mtc0 (en=1, Req=0): writes SR (IM, EXL, IE only) or EPC; writes to Cause, PRId, other numbers ignored.
REQ-020 Req=1 and en=1 same cycle: mtc0 suppressed; exception entry only.
REQ-021 EXLClr=1, Req=0: SR.EXL <= 0 next edge; Req and EXLClr together: Req wins, EXL stays 1.
REQ-022 mtc0 to SR with EXL and EXLClr same cycle: EXLClr wins for EXL, mtc0 wins for IM/IE.
REQ-023 CP0Out combinational from register state (pre-write value in a write cycle); EPCOut = EPC register, no bypass; hazard unit stalls eret behind mtc0 EPC.
REQ-024 While SR.EXL=1, no further Req regardless of HWInt/ExcCodeIn (nested entry prohibited).

Reset
REQ-025 reset low: SR=0, Cause=0, EPC=0, Count=0 (if built); Req=0 immediately; CP0Out reflects zeroed registers.
REQ-026 Reset mid-handler clears EXL; pending HWInt raises no Req until software sets IE and IM.

Configuration
REQ-027 Macro CP0_COUNT_EN: when defined, register 9 (Count) exists: 32-bit, +1 per cycle, wraps 0xFFFF_FFFF -> 0, mtc0 to 9 loads CP0In (load beats increment that cycle), readable via mfc0.
REQ-028 Without CP0_COUNT_EN: no Count flops; register 9 reads 0, writes ignored.

Structure
REQ-029 Shared macros file: CP0 register numbers (SR/Cause/EPC/PRId/Count), ExcCode constants (Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12), handler address, PRId value.
REQ-030 Single sub-module cp0_count holds the Count counter, instantiated only under CP0_COUNT_EN; all else flat in cp0_unit.

Verification
REQ-031 SR=0x0000_0401, HWInt=6'b000001, EXL=0 -> Req=1 same cycle; next edge EXL=1, ExcCode=0, EPC=VPC.
REQ-032 ExcCodeIn=10, BDIn=1, VPC=0x0000_3008 -> Req=1; EPC=0x0000_3004, Cause.BD=1, Cause[6:2]=10.
REQ-033 EXL=1, ExcCodeIn=8 -> Req=0, no register change; then EXLClr=1 -> EXL=0 next edge.
REQ-034 en=1, CP0Add=14, CP0In=0x0000_3100 with ExcCodeIn=12 same cycle -> EPC=VPC, not 0x0000_3100.
REQ-035 CP0_COUNT_EN: mtc0 9 <- 0xFFFF_FFFE; mfc0 9 two cycles later reads 0x0000_0000 (wrap).
REQ-036 Assert reset low mid-cycle while EXL=1 -> all registers 0 and Req=0 without clock edge.
